// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-way round-robin arbiter with one-hot grant and max-hold timeout
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam bit               HOLD_ON   = (MAX_HOLD != 0);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;

    logic             found;
    logic [1:0]       win;
    logic [1:0]       cand;

    function automatic logic [3:0] decode2to4(input logic [1:0] s);
        logic [3:0] y;
        y = 4'b0000;
        case (s)
            2'd0:    y = 4'b0001;
            2'd1:    y = 4'b0010;
            2'd2:    y = 4'b0100;
            default: y = 4'b1000;
        endcase
        return y;
    endfunction

    // Search starts one past the last winner, so last winner is considered last.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        cand  = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = GRANT;
                    sel_d      = win;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                end else if (HOLD_ON && (hold_cnt_q == HOLD_LAST)) begin
                    state_d   = IDLE;
                    last_d    = sel_q;
                    timeout_d = 1'b1;
                end else if (HOLD_ON) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Grant is registered from next-state so it moves only at grant/release.
        gnt_d       = (state_d == GRANT) ? decode2to4(sel_d) : 4'b0000;
        gnt_valid_d = (state_d == GRANT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            last_q      <= 2'd3;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - scoreboard bench for rr_arbiter_4 with MAX_HOLD=8 and MAX_HOLD=0
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req8, req0;
    logic [3:0] gnt8, gnt0;
    logic [1:0] sel8, sel0;
    logic       v8, v0;
    logic       to8, to0;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    typedef struct {
        bit         which;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       to;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t m;
    event chk_ev;

    logic [3:0] a_g;
    logic [1:0] a_s;
    logic       a_v;
    logic       a_t;

    rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(4)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req8),
        .gnt       (gnt8),
        .sel       (sel8),
        .gnt_valid (v8),
        .timeout   (to8)
    );

    rr_arbiter_4 #(.MAX_HOLD(0), .CNT_W(4)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req0),
        .gnt       (gnt0),
        .sel       (sel0),
        .gnt_valid (v0),
        .timeout   (to0)
    );

    always #5 clk = ~clk;

    always begin
        @(negedge clk or chk_ev);
        if (sb_q.size() != 0) begin
            m = sb_q.pop_front();
            if (m.which) begin
                a_g = gnt8; a_s = sel8; a_v = v8; a_t = to8;
            end else begin
                a_g = gnt0; a_s = sel0; a_v = v0; a_t = to0;
            end
            checks++;
            if ({a_g, a_s, a_v, a_t} !== {m.gnt, m.sel, |m.gnt, m.to}) begin
                errors++;
                $display("FAIL %s (dut%0d) @%0t: got gnt=%b sel=%b valid=%b timeout=%b, want gnt=%b sel=%b valid=%b timeout=%b",
                         m.name, m.which ? 8 : 0, $time, a_g, a_s, a_v, a_t, m.gnt, m.sel, |m.gnt, m.to);
            end
        end
    end

    initial begin
        #100000;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL watchdog @%0t: sequence did not finish in time", $time);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic check_direct(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got {gnt,sel,valid,timeout}=%b want %b", nm, $time, got, want);
        end
    endtask

    task automatic push_exp(input bit w, input logic [3:0] g, input logic [1:0] s,
                            input logic t, input string nm);
        exp_t e;
        e.which = w;
        e.gnt   = g;
        e.sel   = s;
        e.to    = t;
        e.name  = nm;
        sb_q.push_back(e);
    endtask

    task automatic step(input bit w, input logic [3:0] r, input logic [3:0] g,
                        input logic [1:0] s, input logic t, input string nm);
        if (w) req8 = r; else req0 = r;
        @(posedge clk);
        #1;
        push_exp(w, g, s, t, nm);
    endtask

    initial begin
        rst_n = 1'b0;
        req8  = 4'b0000;
        req0  = 4'b0000;
        #2;
        check_direct("reset_direct8", {gnt8, sel8, v8, to8}, 8'b0);
        check_direct("reset_direct0", {gnt0, sel0, v0, to0}, 8'b0);
        push_exp(1'b1, 4'b0000, 2'd0, 1'b0, "reset_state8");
        push_exp(1'b0, 4'b0000, 2'd0, 1'b0, "reset_state0");
        ->chk_ev;
        #1;
        ->chk_ev;
        #9;
        rst_n = 1'b1;

        step(1, 4'b0100, 4'b0100, 2'd2, 0, "single_c1");
        step(1, 4'b0100, 4'b0100, 2'd2, 0, "single_c2");
        step(1, 4'b0100, 4'b0100, 2'd2, 0, "single_c3");
        step(1, 4'b0000, 4'b0000, 2'd2, 0, "single_release");
        step(1, 4'b0000, 4'b0000, 2'd2, 0, "single_idle");

        step(1, 4'b1000, 4'b1000, 2'd3, 0, "wrap_g3");
        step(1, 4'b0000, 4'b0000, 2'd3, 0, "wrap_rel3");
        step(1, 4'b1001, 4'b0001, 2'd0, 0, "wrap_g0");
        step(1, 4'b0000, 4'b0000, 2'd0, 0, "wrap_rel0");

        step(1, 4'b0010, 4'b0010, 2'd1, 0, "hand_g1");
        step(1, 4'b0010, 4'b0010, 2'd1, 0, "hand_hold1");
        step(1, 4'b1000, 4'b0000, 2'd1, 0, "hand_gap");
        step(1, 4'b1000, 4'b1000, 2'd3, 0, "hand_g3");
        step(1, 4'b0000, 4'b0000, 2'd3, 0, "hand_rel3");

        step(1, 4'b0100, 4'b0100, 2'd2, 0, "pre_reset_g2");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        req8  = 4'b0000;
        #1;
        check_direct("async_reset_direct", {gnt8, sel8, v8, to8}, 8'b0);
        push_exp(1'b1, 4'b0000, 2'd0, 1'b0, "async_reset");
        ->chk_ev;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 8; c++)
                step(1, 4'hF, 4'b0001 << (k % 4), 2'(k % 4), 0, "rot_hold");
            step(1, 4'hF, 4'b0000, 2'(k % 4), 1, "rot_timeout");
        end
        step(1, 4'b0000, 4'b0000, 2'd0, 0, "rot_end_idle");

        for (int c = 0; c < 100; c++)
            step(0, 4'b0011, 4'b0001, 2'd0, 0, "unlim_hold");
        step(0, 4'b0010, 4'b0000, 2'd0, 0, "unlim_release");
        step(0, 4'b0010, 4'b0010, 2'd1, 0, "unlim_g1");
        step(0, 4'b0000, 4'b0000, 2'd1, 0, "unlim_rel1");

        repeat (2) @(negedge clk);
        #1;
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
